// File: rtl/i2c_pkg.sv
// Definitions shared by the I2C EEPROM target and the I2C EEPROM reader.
package i2c_pkg;

    localparam logic       I2C_ACK             = 1'b0;
    localparam logic [6:0] EEPROM_ADDR_DEFAULT = 7'b1010000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_MEM_HI,
        ST_ACK_HI,
        ST_MEM_LO,
        ST_ACK_LO,
        ST_WR_DATA,
        ST_ACK_WR,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT,
        ST_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes raw SCL/SDA pins to clk and derives bus events.
// Events are registered: a pin edge becomes an event pulse three clocks later.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_lvl
);

    // [1:0] are the synchronizer stages, [2] is the history flop
    logic [2:0] scl_sh;
    logic [2:0] sda_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sh    <= 3'b111;
            sda_sh    <= 3'b111;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_lvl   <= 1'b1;
        end else begin
            scl_sh    <= {scl_sh[1:0], scl_in};
            sda_sh    <= {sda_sh[1:0], sda_in};
            scl_rise  <= scl_sh[1] & ~scl_sh[2];
            scl_fall  <= ~scl_sh[1] & scl_sh[2];
            start_det <= scl_sh[1] & scl_sh[2] & sda_sh[2] & ~sda_sh[1];
            stop_det  <= scl_sh[1] & scl_sh[2] & ~sda_sh[2] & sda_sh[1];
            sda_lvl   <= sda_sh[1];
        end
    end

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 24xx EEPROM with a 16-bit memory address in front of
// an external synchronous single-port RAM.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   IDLE        | bus free, waiting for START
//   ADDR        | receiving device address + R/W
//   ACK_ADDR    | driving ACK for a matched address
//   MEM_HI/LO   | receiving memory address high / low byte
//   ACK_HI/LO   | driving ACK for a memory address byte
//   WR_DATA     | receiving a write data byte
//   ACK_WR      | driving ACK for a write data byte (RAM write issued)
//   RD_DATA     | shifting a read byte out, MSB first
//   RD_ACK      | sampling master ACK/NACK after a read byte
//   WAIT        | read ended by NACK, waiting for START/STOP
//   IGNORE      | address mismatch, waiting for START/STOP
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = EEPROM_ADDR_DEFAULT,
    parameter int         MEM_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic                  busy
);

    localparam logic [MEM_ADDR_W-1:0] PTR_ONE = MEM_ADDR_W'(1);

    logic       scl_rise, scl_fall, start_det, stop_det, sda_lvl;
    i2c_state_t state;
    logic [7:0] rx_sh;
    logic [7:0] tx_sh;
    logic [7:0] addr_hi;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       re_d;
    logic       byte_done;
    logic [15:0] addr_full;

    assign byte_done = (bit_cnt == 4'd8);
    assign addr_full = {addr_hi, rx_sh};

    i2c_sync_edge u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_lvl   (sda_lvl)
    );

    // mem_addr is the pointer itself; a write bumps it the clock after mem_we
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sda_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            rx_sh     <= 8'h00;
            tx_sh     <= 8'h00;
            addr_hi   <= 8'h00;
            bit_cnt   <= 4'd0;
            rw        <= 1'b0;
            re_d      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            re_d   <= mem_re;
            if (re_d)
                tx_sh <= mem_rdata;
            if (mem_we)
                mem_addr <= mem_addr + PTR_ONE;

            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_MEM_HI, ST_MEM_LO, ST_WR_DATA: begin
                        if (scl_rise && !byte_done) begin
                            rx_sh   <= {rx_sh[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && byte_done) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b1;
                            case (state)
                                ST_ADDR: begin
                                    if (rx_sh[7:1] == SLAVE_ADDR) begin
                                        busy   <= 1'b1;
                                        rw     <= rx_sh[0];
                                        mem_re <= rx_sh[0];
                                        state  <= ST_ACK_ADDR;
                                    end else begin
                                        sda_oe <= 1'b0;
                                        busy   <= 1'b0;
                                        state  <= ST_IGNORE;
                                    end
                                end
                                ST_MEM_HI: begin
                                    addr_hi <= rx_sh;
                                    state   <= ST_ACK_HI;
                                end
                                ST_MEM_LO: begin
                                    mem_addr <= addr_full[MEM_ADDR_W-1:0];
                                    state    <= ST_ACK_LO;
                                end
                                default: begin
                                    mem_we    <= 1'b1;
                                    mem_wdata <= rx_sh;
                                    state     <= ST_ACK_WR;
                                end
                            endcase
                        end
                    end
                    ST_ACK_ADDR: begin
                        if (scl_fall) begin
                            if (rw) begin
                                sda_oe <= ~tx_sh[7];
                                state  <= ST_RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_MEM_HI;
                            end
                        end
                    end
                    ST_ACK_HI: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_MEM_LO;
                        end
                    end
                    ST_ACK_LO, ST_ACK_WR: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                sda_oe <= 1'b0;
                                state  <= ST_RD_ACK;
                            end else if (bit_cnt != 4'd0) begin
                                sda_oe <= ~tx_sh[6];
                                tx_sh  <= {tx_sh[6:0], 1'b0};
                            end else begin
                                sda_oe <= ~tx_sh[7];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            mem_addr <= mem_addr + PTR_ONE;
                            bit_cnt  <= 4'd0;
                            if (sda_lvl == I2C_ACK) begin
                                mem_re <= 1'b1;
                                state  <= ST_RD_DATA;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
